// File: rtl/wire4_fanout_pkg.sv
// rtl/wire4_fanout_pkg.sv - output-mode constants for the 3-to-4 fanout glue block
package wire4_fanout_pkg;

  // Values accepted by the REG_OUT parameter
  localparam int COMB = 0;
  localparam int REGD = 1;

endpackage

// File: rtl/wire4_fanout_reg.sv
// rtl/wire4_fanout_reg.sv - WIDTH-bit register with synchronous active-high clear
module wire4_fanout_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on each rising edge; reset wins over the sampled data
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/wire4_fanout.sv
// rtl/wire4_fanout.sv - fans a, b, c out to w=a, x=b, y=b, z=c with optional output flops
module wire4_fanout
  import wire4_fanout_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = COMB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  if (REG_OUT == REGD) begin : g_reg
    // x and y get separate flops fed from the same b, so they stay identical
    // through reset and afterwards while giving each consumer its own driver
    wire4_fanout_reg #(.WIDTH(WIDTH)) u_reg_w (.clk(clk), .rst(rst), .d(a), .q(w));
    wire4_fanout_reg #(.WIDTH(WIDTH)) u_reg_x (.clk(clk), .rst(rst), .d(b), .q(x));
    wire4_fanout_reg #(.WIDTH(WIDTH)) u_reg_y (.clk(clk), .rst(rst), .d(b), .q(y));
    wire4_fanout_reg #(.WIDTH(WIDTH)) u_reg_z (.clk(clk), .rst(rst), .d(c), .q(z));
  end else begin : g_comb
    // Pure wiring: clk and rst have no effect in this mode
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};

    assign w = a;
    assign x = b;
    assign y = b;
    assign z = c;
  end

endmodule

// File: tb/tb_wire4_fanout.sv
// tb/tb_wire4_fanout.sv - self-checking bench for wire4_fanout in both output modes
module tb_wire4_fanout;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b, c;
  logic [7:0] cw, cx, cy, cz;
  logic [7:0] rw, rx, ry, rz;
  logic       a1, b1, c1;
  logic       w1, x1, y1, z1;

  int checks = 0;
  int errors = 0;

  bit check_en = 1'b0;
  bit have_sample = 1'b0;
  bit s_rst;
  logic [7:0] s_a, s_b, s_c;

  always #5 clk = ~clk;

  wire4_fanout #(.WIDTH(8), .REG_OUT(0)) dut_c8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .w(cw), .x(cx), .y(cy), .z(cz)
  );

  wire4_fanout #(.WIDTH(8), .REG_OUT(1)) dut_r8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .w(rw), .x(rx), .y(ry), .z(rz)
  );

  wire4_fanout #(.WIDTH(1), .REG_OUT(0)) dut_c1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1),
    .w(w1), .x(x1), .y(y1), .z(z1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] map8(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic);
    return {ia, ib, ib, ic};
  endfunction

  // Remember what the registered instance should have captured at the last edge
  always @(posedge clk) begin
    s_rst <= rst;
    s_a <= a;
    s_b <= b;
    s_c <= c;
    have_sample <= 1'b1;
  end

  // Continuous comparison against the reference mapping, sampled mid-cycle
  always @(negedge clk) begin
    if (check_en) begin
      check("comb8_map", {cw, cx, cy, cz}, map8(a, b, c));
      check("comb8_xy", {24'd0, cx}, {24'd0, cy});
      if (have_sample) begin
        check("reg8_map", {rw, rx, ry, rz}, s_rst ? 32'd0 : map8(s_a, s_b, s_c));
      end
      check("reg8_xy", {24'd0, rx}, {24'd0, ry});
      check("comb1_map", {28'd0, w1, x1, y1, z1}, {28'd0, a1, b1, b1, c1});
    end
  end

  logic [2:0] sweep [9];
  int spacing;

  initial begin
    sweep = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};

    // Reset held for two edges with all-ones inputs
    rst = 1'b1;
    a = 8'hFF; b = 8'hFF; c = 8'hFF;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    @(posedge clk); #1;
    check("reg_reset_e1", {rw, rx, ry, rz}, 32'h0000_0000);
    @(posedge clk); #1;
    check("reg_reset_e2", {rw, rx, ry, rz}, 32'h0000_0000);
    check("comb_ignores_rst", {cw, cx, cy, cz}, 32'hFFFF_FFFF);
    check_en = 1'b1;

    // First edge after release captures the held inputs
    rst = 1'b0;
    @(posedge clk); #1;
    check("reg_release", {rw, rx, ry, rz}, 32'hFFFF_FFFF);

    // One-cycle latency: abc=001 then abc=110
    a = 8'h00; b = 8'h00; c = 8'h01;
    @(posedge clk); #1;
    check("reg_lat_001", {rw, rx, ry, rz}, 32'h0000_0001);
    a = 8'h01; b = 8'h01; c = 8'h00;
    @(posedge clk); #1;
    check("reg_lat_110", {rw, rx, ry, rz}, 32'h0101_0100);

    // Wide combinational pattern
    a = 8'hA5; b = 8'h3C; c = 8'hFF;
    #1;
    check("comb8_pattern", {cw, cx, cy, cz}, 32'hA53C_3CFF);

    // Hand-computed single-bit cases
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b1; #1;
    check("comb1_011", {28'd0, w1, x1, y1, z1}, 32'h7);
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; #1;
    check("comb1_101", {28'd0, w1, x1, y1, z1}, 32'h9);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; #1;
    check("comb1_110", {28'd0, w1, x1, y1, z1}, 32'hE);

    // Asynchronous sweep of all abc codes on the 1-bit instance
    check_en = 1'b0;
    foreach (sweep[i]) begin
      {a1, b1, c1} = sweep[i];
      #1;
      check("comb1_sweep", {28'd0, w1, x1, y1, z1},
            {28'd0, sweep[i][2], sweep[i][1], sweep[i][1], sweep[i][0]});
      spacing = $urandom_range(15, 5);
      #(spacing - 1);
    end

    // Reset and clock toggling leave the combinational 1-bit outputs alone
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rst = ~rst;
      #2;
      check("comb1_rst_toggle", {28'd0, w1, x1, y1, z1}, 32'hF);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_en = 1'b1;

    // Random traffic with occasional resets
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 8'($urandom);
      {a1, b1, c1} = 3'($urandom);
      rst = ($urandom_range(31, 0) == 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
